exception_ctrl: RTL and testbench

EXCEPTION_CTRL -- requirements
Module: exception_ctrl

---
 rtl/exc_defs.sv | 48 ++++
 rtl/exception_ctrl.sv | 112 +++++++++++
 tb/tb_exception_ctrl.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/exc_defs.sv
// Shared constants for the exception-entry controller: FSM state codes,
// memory-address mux select codes and latched cause codes, plus the
// priority encoder and cause-to-vector mapping used by the control unit.
package exc_defs;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_SAVE = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_LOAD = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  // Memory-address mux select codes (PC, and the three handler vector slots)
  localparam logic [2:0] SEL_PC      = 3'b001;
  localparam logic [2:0] SEL_VEC_OPC = 3'b011;  // address 253
  localparam logic [2:0] SEL_VEC_OVF = 3'b100;  // address 254
  localparam logic [2:0] SEL_VEC_DIV = 3'b101;  // address 255

  // Latched cause codes
  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_OPC  = 2'b01;
  localparam logic [1:0] CAUSE_OVF  = 2'b10;
  localparam logic [1:0] CAUSE_DIV  = 2'b11;

  // Priority: overflow beats divide-by-zero beats invalid opcode.
  function automatic logic [1:0] prio_cause(input logic ovf, input logic div,
                                            input logic opc);
    logic [1:0] c;
    c = CAUSE_NONE;
    if (ovf)      c = CAUSE_OVF;
    else if (div) c = CAUSE_DIV;
    else if (opc) c = CAUSE_OPC;
    return c;
  endfunction

  // Handler vector slot for a latched cause; NONE falls back to the PC path.
  function automatic logic [2:0] vec_sel(input logic [1:0] cause);
    logic [2:0] s;
    case (cause)
      CAUSE_OPC: s = SEL_VEC_OPC;
      CAUSE_OVF: s = SEL_VEC_OVF;
      CAUSE_DIV: s = SEL_VEC_DIV;
      default:   s = SEL_PC;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/exception_ctrl.sv
// Exception-entry sequencer: saves EPC, reads the handler vector byte from
// memory and loads it into PC. Entry takes MEM_LAT+3 cycles after the request
// edge; new requests are ignored while busy (main control stalls on busy).
module exception_ctrl
  import exc_defs::*;
#(
  parameter int          MEM_LAT    = 2,      // memory wait cycles, 1..15
  parameter logic [31:0] EPC_OFFSET = 32'd4   // PC is already incremented
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        exc_opcode,
  input  logic        exc_overflow,
  input  logic        exc_divzero,
  input  logic [31:0] pc_in,
  input  logic [31:0] mem_data_in,
  output logic [2:0]  iord_sel,
  output logic [31:0] epc_out,
  output logic        epc_wr,
  output logic [31:0] pc_out,
  output logic        pc_wr,
  output logic [1:0]  cause_out,
  output logic        busy,
  output logic        done
);

  localparam logic [3:0] LP_LAT = 4'(MEM_LAT);

  logic [2:0]  r_state;
  logic [3:0]  r_cnt;
  logic [1:0]  r_cause;
  logic [31:0] r_epc;
  logic [31:0] r_pc;

  logic        w_any_req;
  logic [1:0]  w_cause;
  logic        w_unused_hi;

  assign w_any_req   = exc_opcode | exc_overflow | exc_divzero;
  assign w_cause     = prio_cause(exc_overflow, exc_divzero, exc_opcode);
  // Only the low byte of the vector word carries the handler address.
  assign w_unused_hi = ^mem_data_in[31:8];

  // State sequencing and the memory wait down-counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_any_req) r_state <= ST_SAVE;
        ST_SAVE: begin
          r_cnt   <= LP_LAT;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (r_cnt <= 4'd1) begin
            r_cnt   <= 4'd0;
            r_state <= ST_LOAD;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_LOAD: r_state <= ST_DONE;
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Cause and EPC are captured on the accepting edge so both are stable
  // for the whole SAVE cycle in which EPC is written.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cause <= CAUSE_NONE;
      r_epc   <= 32'd0;
    end else if (r_state == ST_IDLE && w_any_req) begin
      r_cause <= w_cause;
      r_epc   <= pc_in - EPC_OFFSET;
    end
  end

  // Handler byte is captured on the last wait edge, valid through LOAD.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pc <= 32'd0;
    end else if (r_state == ST_WAIT && r_cnt <= 4'd1) begin
      r_pc <= {24'd0, mem_data_in[7:0]};
    end
  end

  // Moore decode of strobes and the address mux select.
  always_comb begin
    iord_sel = SEL_PC;
    epc_wr   = 1'b0;
    pc_wr    = 1'b0;
    done     = 1'b0;
    busy     = (r_state != ST_IDLE);
    if (r_state != ST_IDLE) iord_sel = vec_sel(r_cause);
    case (r_state)
      ST_SAVE: epc_wr = 1'b1;
      ST_LOAD: pc_wr  = 1'b1;
      ST_DONE: done   = 1'b1;
      default: ;
    endcase
  end

  assign epc_out   = r_epc;
  assign pc_out    = r_pc;
  assign cause_out = r_cause;

endmodule

// File: tb/tb_exception_ctrl.sv
// Bench for exception_ctrl: three instances (MEM_LAT 2, 1, 15), one active at
// a time. Stimulus pushes expected EPC/PC/done events into a queue; a monitor
// pops and compares whenever the active instance raises a strobe.
module tb_exception_ctrl;

  typedef struct {
    int          kind;   // 0 epc_wr, 1 pc_wr, 2 done
    int          cyc;
    logic [31:0] val;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        exc_o [3];
  logic        exc_v [3];
  logic        exc_d [3];
  logic [31:0] pc_in, mem_data_in;

  logic [2:0]  iord_a  [3];
  logic [31:0] epc_a   [3];
  logic [31:0] pco_a   [3];
  logic        epcwr_a [3];
  logic        pcwr_a  [3];
  logic        busy_a  [3];
  logic        done_a  [3];
  logic [1:0]  cause_a [3];

  int    lats [3] = '{2, 1, 15};
  string kname [3] = '{"epc_wr", "pc_wr", "done"};
  logic [31:0] bnd [6] = '{32'h0, 32'h1, 32'h2, 32'h3, 32'h4, 32'hFFFF_FFFF};

  int   sel = 0;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  ev_t  q [$];
  int   next_free = 0;
  int   b_start = 1 << 30;
  int   b_end = -1;
  logic [2:0] b_vec = 3'b001;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 15);
    exception_ctrl #(.MEM_LAT(LAT), .EPC_OFFSET(32'd4)) u_dut (
      .clk(clk), .reset_n(reset_n),
      .exc_opcode(exc_o[g]), .exc_overflow(exc_v[g]), .exc_divzero(exc_d[g]),
      .pc_in(pc_in), .mem_data_in(mem_data_in),
      .iord_sel(iord_a[g]), .epc_out(epc_a[g]), .epc_wr(epcwr_a[g]),
      .pc_out(pco_a[g]), .pc_wr(pcwr_a[g]), .cause_out(cause_a[g]),
      .busy(busy_a[g]), .done(done_a[g])
    );
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s dut=%0d cyc=%0d actual=%h expected=%h", name, sel, cyc, act, exp);
    end
  endtask

  task automatic pop_cmp(input int kind, input logic [31:0] act);
    ev_t ev;
    if (q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL unexpected_%s dut=%0d cyc=%0d actual=%h expected=none",
               kname[kind], sel, cyc, act);
    end else begin
      ev = q.pop_front();
      chk({kname[kind], "_order"}, 32'(kind), 32'(ev.kind));
      chk({kname[kind], "_cycle"}, 32'(cyc), 32'(ev.cyc));
      chk({kname[kind], "_value"}, act, ev.val);
    end
  endtask

  task automatic rst_chk(input int g);
    chk("rst_iord_sel", 32'(iord_a[g]), 32'h1);
    chk("rst_epc_out", epc_a[g], 32'h0);
    chk("rst_pc_out", pco_a[g], 32'h0);
    chk("rst_cause", 32'(cause_a[g]), 32'h0);
    chk("rst_strobes", {28'd0, epcwr_a[g], pcwr_a[g], busy_a[g], done_a[g]}, 32'h0);
  endtask

  // Monitor: per-cycle busy/iord_sel against the model window, plus events.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (reset_n === 1'b1) begin
        automatic logic exp_busy = (cyc >= b_start) && (cyc <= b_end);
        chk("busy", 32'(busy_a[sel]), 32'(exp_busy));
        chk("iord_sel", 32'(iord_a[sel]), exp_busy ? 32'(b_vec) : 32'h1);
        chk("overdue_event", 32'(q.size() > 0 && q[0].cyc < cyc), 32'h0);
        if (epcwr_a[sel]) pop_cmp(0, epc_a[sel]);
        if (pcwr_a[sel])  pop_cmp(1, pco_a[sel]);
        if (done_a[sel])  pop_cmp(2, {30'd0, cause_a[sel]});
      end
    end
  end

  // One input cycle; the reference model decides acceptance and predicts
  // the whole entry from the documented timing rules.
  task automatic drive(input logic o, input logic v, input logic d,
                       input logic [31:0] pc, input logic [31:0] md);
    int n, lat, cause;
    logic [2:0] vec;
    @(negedge clk);
    n = cyc;  // edge that will sample these inputs
    if ((o | v | d) && n >= next_free) begin
      lat = lats[sel];
      if (v)      begin cause = 2; vec = 3'b100; end
      else if (d) begin cause = 3; vec = 3'b101; end
      else        begin cause = 1; vec = 3'b011; end
      pc_in = pc;
      mem_data_in = md;
      q.push_back(ev_t'{kind: 0, cyc: n + 1,       val: pc - 32'd4});
      q.push_back(ev_t'{kind: 1, cyc: n + 2 + lat, val: {24'd0, md[7:0]}});
      q.push_back(ev_t'{kind: 2, cyc: n + 3 + lat, val: 32'(cause)});
      b_start   = n + 1;
      b_end     = n + 3 + lat;
      b_vec     = vec;
      next_free = n + 4 + lat;
    end
    for (int g = 0; g < 3; g++) begin
      exc_o[g] = (g == sel) ? o : 1'b0;
      exc_v[g] = (g == sel) ? v : 1'b0;
      exc_d[g] = (g == sel) ? d : 1'b0;
    end
  endtask

  task automatic drain();
    int k = 0;
    while ((q.size() != 0 || cyc <= b_end + 1) && k < 100) begin
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      k++;
    end
    if (k >= 100) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout dut=%0d cyc=%0d actual=%0d_pending expected=0", sel, cyc, q.size());
    end
  endtask

  task automatic random_phase(input int ncyc);
    logic [2:0]  bits;
    logic [31:0] pc;
    for (int i = 0; i < ncyc; i++) begin
      bits = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      pc   = ($urandom_range(0, 3) == 0) ? bnd[$urandom_range(0, 5)] : $urandom;
      drive(bits[0], bits[1], bits[2], pc, $urandom);
    end
    drain();
  endtask

  // Reset asserted during WAIT: outputs must drop at once, then no strobes.
  task automatic reset_mid_wait();
    int k = 0;
    drive(1'b0, 1'b0, 1'b1, 32'h0000_1000, 32'h0000_00C3);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    while (cyc < b_start + 1 && k < 50) begin
      @(posedge clk);
      k++;
    end
    #3;
    reset_n = 1'b0;
    #1;
    rst_chk(sel);
    q.delete();
    b_start   = 1 << 30;
    b_end     = -1;
    repeat (2) @(negedge clk);
    reset_n   = 1'b1;
    next_free = cyc;
    repeat (lats[sel] + 6) drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    reset_n     = 1'b0;
    pc_in       = 32'h0;
    mem_data_in = 32'h0;
    for (int g = 0; g < 3; g++) begin
      exc_o[g] = 1'b0;
      exc_v[g] = 1'b0;
      exc_d[g] = 1'b0;
    end
    #1;
    for (int g = 0; g < 3; g++) rst_chk(g);
    repeat (3) @(negedge clk);
    reset_n   = 1'b1;
    next_free = cyc;

    // MEM_LAT = 2
    sel = 0;
    drive(1'b1, 1'b0, 1'b0, 32'h0000_0040, 32'h0000_00A5);
    drain();
    drive(1'b0, 1'b1, 1'b1, 32'h0000_1234, 32'h0000_0077);
    drain();
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0002, 32'h0000_0033);
    drain();
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0100, 32'h0000_0011);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0900, 32'h0000_0099);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drain();
    for (int i = 0; i < 13; i++)
      drive(1'b0, 1'b0, 1'b1, 32'h0000_0200 + 32'(i), 32'h0000_0020 + 32'(i));
    drain();
    reset_mid_wait();
    random_phase(200);

    // MEM_LAT = 1
    sel = 1;
    drive(1'b1, 1'b0, 1'b0, 32'h0000_0040, 32'hFFFF_FF10);
    drain();
    random_phase(150);

    // MEM_LAT = 15
    sel = 2;
    drive(1'b0, 1'b1, 1'b0, 32'h0000_0000, 32'hFFFF_FF10);
    drain();
    reset_mid_wait();
    random_phase(250);

    chk("queue_empty", 32'(q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
